// File: rtl/starsoc_params.sv
// rtl/starsoc_params.sv - display timing constants and sprite renderer definitions
package starsoc_params;

    localparam logic [9:0]  H_VISIBLE = 10'd640;
    localparam logic [9:0]  H_MAX     = 10'd800;
    localparam logic [9:0]  V_VISIBLE = 10'd480;
    localparam logic [9:0]  V_MAX     = 10'd525;

    localparam logic [10:0] SPR_SIZE  = 11'd16;

    // Attributes live at 0x00-0x0F (4 per sprite), bitmap rows at 0x40-0x7F.
    localparam logic [7:0]  ATTR_BASE = 8'h00;
    localparam logic [7:0]  BMP_BASE  = 8'h40;

    localparam logic [1:0]  ATTR_X     = 2'd0;
    localparam logic [1:0]  ATTR_Y     = 2'd1;
    localparam logic [1:0]  ATTR_COLOR = 2'd2;
    localparam logic [1:0]  ATTR_EN    = 2'd3;

    typedef enum logic [3:0] {
        PREP_IDLE,
        PREP_RD0,
        PREP_CAP0,
        PREP_RD1,
        PREP_CAP1,
        PREP_RD2,
        PREP_CAP2,
        PREP_RD3,
        PREP_CAP3,
        PREP_DONE
    } prep_state_e;

endpackage

// File: rtl/sprite_bitmap_ram.sv
// rtl/sprite_bitmap_ram.sv - 64x16 simple dual-port bitmap RAM, registered read-before-write
module sprite_bitmap_ram (
    input  logic        clk_i,
    input  logic        we_i,
    input  logic [5:0]  waddr_i,
    input  logic [15:0] wdata_i,
    input  logic        re_i,
    input  logic [5:0]  raddr_i,
    output logic [15:0] rdata_o
);

    logic [15:0] mem_q [64];
    logic [15:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sprite_line_renderer.sv
// rtl/sprite_line_renderer.sv - four 16x16 1-bpp sprites composited over a background colour
module sprite_line_renderer
    import starsoc_params::*;
#(
    parameter int          N_SPRITES = 4,
    parameter logic [11:0] BG_COLOR  = 12'h000
) (
    input  logic        pixel_clk,
    input  logic        reset_n,
    input  logic        vtg_ce,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        video_on_in,
    input  logic        wr_en,
    input  logic [7:0]  wr_addr,
    input  logic [15:0] wr_data,
    output logic [11:0] rgb,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        video_on_out,
    output logic        line_busy
);

    localparam logic [9:0] H_LAST = H_MAX - 10'd1;
    localparam logic [9:0] V_LAST = V_MAX - 10'd1;

    logic [9:0]  x_q   [N_SPRITES];
    logic [9:0]  y_q   [N_SPRITES];
    logic [11:0] col_q [N_SPRITES];
    logic        en_q  [N_SPRITES];

    logic attr_we;
    logic bmp_we;

    assign attr_we = wr_en && (wr_addr[7:4] == ATTR_BASE[7:4]);
    assign bmp_we  = wr_en && (wr_addr[7:6] == BMP_BASE[7:6]);

    // Register writes ignore vtg_ce so the CPU is never stalled by the pixel rate.
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_SPRITES; i++) begin
                x_q[i]   <= '0;
                y_q[i]   <= '0;
                col_q[i] <= '0;
                en_q[i]  <= 1'b0;
            end
        end else if (attr_we) begin
            case (wr_addr[1:0])
                ATTR_X:     x_q[wr_addr[3:2]]   <= wr_data[9:0];
                ATTR_Y:     y_q[wr_addr[3:2]]   <= wr_data[9:0];
                ATTR_COLOR: col_q[wr_addr[3:2]] <= wr_data[11:0];
                default:    en_q[wr_addr[3:2]]  <= wr_data[0];
            endcase
        end
    end

    prep_state_e state_q, state_d;
    logic [9:0]  tgt_q;
    logic        miss_q;
    logic [1:0]  idx;
    logic        is_rd, is_cap;
    logic        prep_start, prep_commit;
    logic [10:0] row;
    logic        row_hit;
    logic        ram_re;
    logic [5:0]  ram_raddr;
    logic [15:0] ram_rdata;

    logic [15:0] nxt_bits_q [N_SPRITES];
    logic [9:0]  nxt_x_q    [N_SPRITES];
    logic [11:0] nxt_col_q  [N_SPRITES];
    logic [15:0] cur_bits_q [N_SPRITES];
    logic [9:0]  cur_x_q    [N_SPRITES];
    logic [11:0] cur_col_q  [N_SPRITES];

    assign prep_start  = (state_q == PREP_IDLE) && (pixel_x == H_VISIBLE);
    assign prep_commit = (state_q == PREP_DONE) && (pixel_x == H_LAST);
    assign line_busy   = (state_q != PREP_IDLE) && (state_q != PREP_DONE);

    always_comb begin
        state_d = state_q;
        idx     = 2'd0;
        is_rd   = 1'b0;
        is_cap  = 1'b0;
        case (state_q)
            PREP_IDLE: if (prep_start) state_d = PREP_RD0;
            PREP_RD0:  begin is_rd  = 1'b1; idx = 2'd0; state_d = PREP_CAP0; end
            PREP_CAP0: begin is_cap = 1'b1; idx = 2'd0; state_d = PREP_RD1;  end
            PREP_RD1:  begin is_rd  = 1'b1; idx = 2'd1; state_d = PREP_CAP1; end
            PREP_CAP1: begin is_cap = 1'b1; idx = 2'd1; state_d = PREP_RD2;  end
            PREP_RD2:  begin is_rd  = 1'b1; idx = 2'd2; state_d = PREP_CAP2; end
            PREP_CAP2: begin is_cap = 1'b1; idx = 2'd2; state_d = PREP_RD3;  end
            PREP_RD3:  begin is_rd  = 1'b1; idx = 2'd3; state_d = PREP_CAP3; end
            PREP_CAP3: begin is_cap = 1'b1; idx = 2'd3; state_d = PREP_DONE; end
            PREP_DONE: if (prep_commit) state_d = PREP_IDLE;
            default:   state_d = PREP_IDLE;
        endcase
    end

    // A negative difference sets bit 10, so one unsigned compare covers both bounds.
    assign row       = {1'b0, tgt_q} - {1'b0, y_q[idx]};
    assign row_hit   = en_q[idx] && (row < SPR_SIZE);
    assign ram_re    = vtg_ce && is_rd && row_hit;
    assign ram_raddr = {idx, row[3:0]};

    sprite_bitmap_ram u_bitmap_ram (
        .clk_i   (pixel_clk),
        .we_i    (bmp_we),
        .waddr_i (wr_addr[5:0]),
        .wdata_i (wr_data),
        .re_i    (ram_re),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= PREP_IDLE;
            tgt_q   <= '0;
            miss_q  <= 1'b0;
            for (int i = 0; i < N_SPRITES; i++) begin
                nxt_bits_q[i] <= '0;
                nxt_x_q[i]    <= '0;
                nxt_col_q[i]  <= '0;
                cur_bits_q[i] <= '0;
                cur_x_q[i]    <= '0;
                cur_col_q[i]  <= '0;
            end
        end else if (vtg_ce) begin
            state_q <= state_d;
            if (prep_start) begin
                tgt_q <= (pixel_y == V_LAST) ? 10'd0 : pixel_y + 10'd1;
            end
            if (is_rd) begin
                miss_q <= !row_hit;
            end
            if (is_cap) begin
                nxt_bits_q[idx] <= miss_q ? 16'h0000 : ram_rdata;
                nxt_x_q[idx]    <= x_q[idx];
                nxt_col_q[idx]  <= col_q[idx];
            end
            if (prep_commit) begin
                for (int i = 0; i < N_SPRITES; i++) begin
                    cur_bits_q[i] <= nxt_bits_q[i];
                    cur_x_q[i]    <= nxt_x_q[i];
                    cur_col_q[i]  <= nxt_col_q[i];
                end
            end
        end
    end

    logic [9:0]  px1_q;
    logic        hs1_q, vs1_q, vo1_q;
    logic [11:0] rgb_q;
    logic        hs2_q, vs2_q, vo2_q;
    logic [10:0] dx [N_SPRITES];
    logic [N_SPRITES-1:0] hit;
    logic [11:0] pix_col;

    // Scan from the highest index down so the lowest-index hit overrides.
    always_comb begin
        dx      = '{default: '0};
        hit     = '0;
        pix_col = BG_COLOR;
        for (int i = N_SPRITES - 1; i >= 0; i--) begin
            dx[i]  = {1'b0, px1_q} - {1'b0, cur_x_q[i]};
            hit[i] = (dx[i] < SPR_SIZE) && cur_bits_q[i][4'd15 - dx[i][3:0]];
            if (hit[i]) begin
                pix_col = cur_col_q[i];
            end
        end
    end

    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            px1_q <= '0;
            hs1_q <= 1'b0;
            vs1_q <= 1'b0;
            vo1_q <= 1'b0;
            rgb_q <= '0;
            hs2_q <= 1'b0;
            vs2_q <= 1'b0;
            vo2_q <= 1'b0;
        end else if (vtg_ce) begin
            px1_q <= pixel_x;
            hs1_q <= hsync_in;
            vs1_q <= vsync_in;
            vo1_q <= video_on_in;
            rgb_q <= vo1_q ? pix_col : 12'h000;
            hs2_q <= hs1_q;
            vs2_q <= vs1_q;
            vo2_q <= vo1_q;
        end
    end

    assign rgb          = rgb_q;
    assign hsync_out    = hs2_q;
    assign vsync_out    = vs2_q;
    assign video_on_out = vo2_q;

endmodule

// File: doc/sprite_line_renderer.md
# sprite_line_renderer

Pixel-generation stage fed directly by the display timing generator. Holds attributes and 1-bpp bitmaps for four 16x16 sprites, written by the CPU through a simple register port. During horizontal blanking it prepares the sprite row data for the next line. During the visible area it composites sprites over a background colour into 12-bit RGB, with sync and video-enable delayed to match.

## Interface
Parameters:
- N_SPRITES, 4, number of sprites (fixed at 4 for this revision)
- BG_COLOR, 12'h000, background RGB 4:4:4 shown in the visible area where no sprite pixel is set

Ports:
- pixel_clk  in  1  pixel clock
- reset_n  in  1  asynchronous, active-low reset
- vtg_ce  in  1  pixel enable; all pipeline and FSM state advances only when high
- pixel_x  in  10  current horizontal count from the timing generator
- pixel_y  in  10  current vertical count
- hsync_in, vsync_in, video_on_in  in  1 each  timing-generator outputs
- wr_en  in  1  register write strobe, sampled every clock regardless of vtg_ce
- wr_addr  in  8  register address
- wr_data  in  16  write data
- rgb  out  12  pixel colour, {R[3:0],G[3:0],B[3:0]}
- hsync_out, vsync_out, video_on_out  out  1 each  inputs delayed to align with rgb
- line_busy  out  1  high while line preparation is in progress

## Operation
- Address map:
  - 0x00+4i: X[9:0]
  - 0x01+4i: Y[9:0]
  - 0x02+4i: COLOR[11:0]
  - 0x03+4i: EN[0]
  - 0x40+16i+r: bitmap row r of sprite i (bit 15 = leftmost pixel)
  - Unmapped writes are ignored.
- Attribute registers reset to 0, so all sprites are disabled. The bitmap RAM (64x16, one read port plus one write port) is not reset.
- Line-prep FSM (advances on vtg_ce):
  - IDLE → RD0 when pixel_x == H_VISIBLE. Target line T = (pixel_y == V_MAX-1) ? 0 : pixel_y+1.
  - RDi: compute row = T − Y_i with 11-bit arithmetic. If EN_i and 0 ≤ row < 16, issue a RAM read at {i,row[3:0]}; otherwise flag the sprite as miss.
  - CAPi: nxt_bits[i] ← RAM data, or 0 on miss. nxt_x[i] ← X_i and nxt_col[i] ← COLOR_i.
  - Sequence is RD0 → CAP0 → RD1 → … → CAP3 → DONE.
  - DONE → IDLE at pixel_x == H_MAX-1, copying all nxt_* into cur_*.
  - line_busy = state ∉ {IDLE, DONE}.
- Attribute writes take effect at the next RDi that reads them. A bitmap write to the address being read in the same clock returns old data (read-before-write).
- Pixel pipeline, per vtg_ce:
  - S1 registers pixel_x and the sync/video signals. For each sprite, hit_i = cur_bits[i][15 − (pixel_x − cur_x[i])] when cur_x[i] ≤ pixel_x < cur_x[i]+16, evaluated in 11 bits with no wrap.
  - S2 selects the lowest-index sprite with hit set and outputs its colour, else BG_COLOR. rgb is forced to 0 when the delayed video_on is low.

## Timing
- Latency is 2 vtg_ce cycles from inputs to rgb/hsync_out/vsync_out/video_on_out. Outputs hold their value when vtg_ce is low.
- Line prep takes 8 vtg_ce cycles, well inside the 160-pixel horizontal blank.
- Reset values: rgb = 0, all syncs and video_on_out = 0, line_busy = 0, FSM = IDLE, cur_*/nxt_* = 0.
- Reset asserted mid-line or mid-prep aborts immediately. The first line after reset renders no sprites.
- A sprite at X = 630 draws pixels 630–639 only; its off-screen columns are masked by video_on.
- A sprite at Y = 475 draws rows 0–4 only. Sprite rows are never wrapped onto the top of the next frame.
- Two sprites overlapping on the same pixel: the lower index wins.
- wr_en with vtg_ce low still performs the write.

## Structure
- starsoc_params supplies H_VISIBLE, H_MAX, V_VISIBLE and V_MAX. Add to it SPR_SIZE = 16, the address-map base constants, and a prep-state enum typedef.
- Sub-module sprite_bitmap_ram: 64x16 simple dual-port RAM, synchronous read, read-before-write.

## Test plan
- Reset, then run one full frame with no writes → rgb == 0 outside the visible area, BG_COLOR inside; syncs equal the inputs delayed by 2 ce cycles.
- Sprite 0 at X=100, Y=50, COLOR=12'hF00, EN=1, all bitmap rows 16'hFFFF → rgb = F00 exactly for x 100–115, y 50–65; line_busy pulses for 8 ce cycles starting at pixel_x = 640.
- Sprite 0 row 0 = 16'h8001 → only x = 100 and x = 115 are red on line 50.
- Sprites 0 and 1 both at (200,200), colours F00 and 0F0 → F00 is shown; disabling sprite 0 mid-frame makes 0F0 appear from the next line onward.
- Sprite at X=630 and a sprite at Y=475 → clipped as specified, nothing appears at x = 0 or y = 0; vtg_ce toggling at 1/2 rate gives identical output content.
- Assert reset_n low during line prep → all outputs 0 asynchronously; after release the FSM is in IDLE and line_busy = 0.
